// File: rtl/fu_tag_table.sv
// Per-wavefront functional-unit tag store: one valid bit and FU tag per wavefront,
// exported as registered per-FU wavefront masks and per-FU occupancy counts.
module fu_tag_table #(
   parameter int NUM_WF = 40,
   parameter int WFID_W = 6,
   parameter int NUM_FU = 4,
   parameter int FU_W   = 2,
   parameter int CNT_W  = 6
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_fu_en,
   input  logic [WFID_W-1:0]        wr_wfid,
   input  logic [FU_W-1:0]          wr_fu_value,
   input  logic                     clr_en,
   input  logic [WFID_W-1:0]        clr_wfid,
   output logic [NUM_FU*NUM_WF-1:0] rd_fu_mask,
   output logic [NUM_FU*CNT_W-1:0]  rd_fu_cnt,
   output logic                     err_pulse
);

   localparam logic [WFID_W:0] WF_LIM = (WFID_W+1)'(NUM_WF);
   localparam logic [FU_W:0]   FU_LIM = (FU_W+1)'(NUM_FU);

   logic [NUM_WF-1:0]        r_valid;
   logic [FU_W-1:0]          r_tag [NUM_WF];

   logic                     w_wr_ok;
   logic                     w_clr_ok;
   logic                     w_err;
   logic [NUM_WF-1:0]        w_valid_nxt;
   logic [FU_W-1:0]          w_tag_nxt [NUM_WF];
   logic [NUM_FU*NUM_WF-1:0] w_mask_nxt;
   logic [CNT_W-1:0]         w_cnt_nxt [NUM_FU];

   assign w_wr_ok  = wr_fu_en && ({1'b0, wr_wfid} < WF_LIM) && ({1'b0, wr_fu_value} < FU_LIM);
   assign w_clr_ok = clr_en && ({1'b0, clr_wfid} < WF_LIM);
   assign w_err    = (wr_fu_en && !w_wr_ok) || (clr_en && !w_clr_ok);

   // Clear is applied first so a same-entry write overrides it.
   always_comb begin
      w_valid_nxt = r_valid;
      for (int w = 0; w < NUM_WF; w++) begin
         w_tag_nxt[w] = r_tag[w];
      end
      if (w_clr_ok) begin
         w_valid_nxt[clr_wfid] = 1'b0;
      end
      if (w_wr_ok) begin
         w_valid_nxt[wr_wfid] = 1'b1;
         w_tag_nxt[wr_wfid]   = wr_fu_value;
      end
   end

   always_comb begin
      w_mask_nxt = '0;
      for (int f = 0; f < NUM_FU; f++) begin
         for (int w = 0; w < NUM_WF; w++) begin
            w_mask_nxt[f*NUM_WF+w] = w_valid_nxt[w] && (w_tag_nxt[w] == FU_W'(f));
         end
      end
   end

   // Counts are recomputed from the next-state masks, so simultaneous +1/-1 net out.
   always_comb begin
      for (int f = 0; f < NUM_FU; f++) begin
         w_cnt_nxt[f] = '0;
         for (int w = 0; w < NUM_WF; w++) begin
            w_cnt_nxt[f] = w_cnt_nxt[f] + CNT_W'(w_mask_nxt[f*NUM_WF+w]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid    <= '0;
         rd_fu_mask <= '0;
         rd_fu_cnt  <= '0;
         err_pulse  <= 1'b0;
         for (int w = 0; w < NUM_WF; w++) begin
            r_tag[w] <= '0;
         end
      end else begin
         r_valid    <= w_valid_nxt;
         rd_fu_mask <= w_mask_nxt;
         err_pulse  <= w_err;
         for (int w = 0; w < NUM_WF; w++) begin
            r_tag[w] <= w_tag_nxt[w];
         end
         for (int f = 0; f < NUM_FU; f++) begin
            rd_fu_cnt[f*CNT_W +: CNT_W] <= w_cnt_nxt[f];
         end
      end
   end

endmodule

// File: tb/tb_fu_tag_table.sv
// Self-checking bench for fu_tag_table: directed scenarios plus randomized traffic
// compared against an entry-array reference model.
module tb_fu_tag_table;

   localparam int NUM_WF = 40;
   localparam int WFID_W = 6;
   localparam int NUM_FU = 4;
   localparam int FU_W   = 2;
   localparam int CNT_W  = 6;
   localparam int MW     = NUM_FU*NUM_WF;
   localparam int CW     = NUM_FU*CNT_W;

   logic              clk;
   logic              rst;
   logic              wr_fu_en;
   logic [WFID_W-1:0] wr_wfid;
   logic [FU_W-1:0]   wr_fu_value;
   logic              clr_en;
   logic [WFID_W-1:0] clr_wfid;
   logic [MW-1:0]     rd_fu_mask;
   logic [CW-1:0]     rd_fu_cnt;
   logic              err_pulse;

   int n_checks = 0;
   int n_errors = 0;

   // reference model: plain per-entry arrays
   bit m_valid [NUM_WF];
   int m_tag   [NUM_WF];
   bit m_err;
   logic [MW-1:0] exp_q [$];

   fu_tag_table #(
      .NUM_WF(NUM_WF), .WFID_W(WFID_W), .NUM_FU(NUM_FU), .FU_W(FU_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst),
      .wr_fu_en(wr_fu_en), .wr_wfid(wr_wfid), .wr_fu_value(wr_fu_value),
      .clr_en(clr_en), .clr_wfid(clr_wfid),
      .rd_fu_mask(rd_fu_mask), .rd_fu_cnt(rd_fu_cnt), .err_pulse(err_pulse)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [MW-1:0] exp_mask();
      logic [MW-1:0] m = '0;
      for (int w = 0; w < NUM_WF; w++)
         if (m_valid[w]) m[m_tag[w]*NUM_WF + w] = 1'b1;
      return m;
   endfunction

   function automatic logic [CW-1:0] exp_cnt();
      logic [CW-1:0] c = '0;
      for (int f = 0; f < NUM_FU; f++) begin
         int n = 0;
         for (int w = 0; w < NUM_WF; w++)
            if (m_valid[w] && m_tag[w] == f) n++;
         c[f*CNT_W +: CNT_W] = CNT_W'(n);
      end
      return c;
   endfunction

   task automatic model_apply();
      int  wid  = int'(wr_wfid);
      int  wval = int'(wr_fu_value);
      int  cid  = int'(clr_wfid);
      bit  wr_ok  = wr_fu_en && wid < NUM_WF && wval < NUM_FU;
      bit  clr_ok = clr_en && cid < NUM_WF;
      if (rst) begin
         for (int w = 0; w < NUM_WF; w++) m_valid[w] = 0;
         m_err = 0;
      end else begin
         m_err = (wr_fu_en && !wr_ok) || (clr_en && !clr_ok);
         if (clr_ok) m_valid[cid] = 0;
         if (wr_ok) begin
            m_valid[wid] = 1;
            m_tag[wid]   = wval;
         end
      end
   endtask

   // driver tasks
   task automatic drive(input bit r, input bit we, input int wid, input int wval,
                        input bit ce, input int cid);
      rst         = r;
      wr_fu_en    = we;
      wr_wfid     = WFID_W'(wid);
      wr_fu_value = FU_W'(wval);
      clr_en      = ce;
      clr_wfid    = WFID_W'(cid);
   endtask

   task automatic tick();
      @(posedge clk);
      model_apply();
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         drive(0, 0, 0, 0, 0, 0);
         tick();
      end
   endtask

   task automatic test_reset();
      drive(1, 0, 0, 0, 0, 0);
      tick();
      tick();
      idle(3);
      n_checks++;
      if (rd_fu_mask !== '0) begin
         n_errors++; $display("FAIL reset_mask got=%h exp=0", rd_fu_mask);
      end
      n_checks++;
      if (rd_fu_cnt !== '0) begin
         n_errors++; $display("FAIL reset_cnt got=%h exp=0", rd_fu_cnt);
      end
      n_checks++;
      if (err_pulse !== 1'b0) begin
         n_errors++; $display("FAIL reset_err got=%b exp=0", err_pulse);
      end
   endtask

   task automatic test_write();
      drive(0, 1, 5, 1, 0, 0);
      #1;
      n_checks++;
      if (rd_fu_mask !== '0) begin
         n_errors++; $display("FAIL write_same_cycle got=%h exp=0", rd_fu_mask);
      end
      tick();
      n_checks++;
      if (rd_fu_mask[45] !== 1'b1 || rd_fu_mask !== exp_mask()) begin
         n_errors++; $display("FAIL write_mask got=%h exp=%h", rd_fu_mask, exp_mask());
      end
      n_checks++;
      if (rd_fu_cnt[1*CNT_W +: CNT_W] !== 6'd1 || rd_fu_cnt !== exp_cnt()) begin
         n_errors++; $display("FAIL write_cnt got=%h exp=%h", rd_fu_cnt, exp_cnt());
      end
   endtask

   task automatic test_retag();
      drive(0, 1, 5, 2, 0, 0);
      tick();
      n_checks++;
      if (rd_fu_mask[45] !== 1'b0 || rd_fu_mask[85] !== 1'b1) begin
         n_errors++; $display("FAIL retag_mask got=%h exp=%h", rd_fu_mask, exp_mask());
      end
      n_checks++;
      if (rd_fu_cnt[1*CNT_W +: CNT_W] !== 6'd0 || rd_fu_cnt[2*CNT_W +: CNT_W] !== 6'd1) begin
         n_errors++; $display("FAIL retag_cnt got=%h exp=%h", rd_fu_cnt, exp_cnt());
      end
      drive(0, 1, 5, 2, 0, 0);
      tick();
      n_checks++;
      if (rd_fu_cnt !== exp_cnt()) begin
         n_errors++; $display("FAIL same_tag_rewrite got=%h exp=%h", rd_fu_cnt, exp_cnt());
      end
   endtask

   task automatic test_same_cycle();
      drive(0, 1, 7, 0, 1, 5);
      tick();
      n_checks++;
      if (rd_fu_cnt[0 +: CNT_W] !== 6'd1 || rd_fu_cnt[2*CNT_W +: CNT_W] !== 6'd0) begin
         n_errors++; $display("FAIL wr_clr_diff got=%h exp=%h", rd_fu_cnt, exp_cnt());
      end
      drive(0, 1, 7, 3, 1, 7);
      tick();
      n_checks++;
      if (rd_fu_cnt[0 +: CNT_W] !== 6'd0 || rd_fu_cnt[3*CNT_W +: CNT_W] !== 6'd1) begin
         n_errors++; $display("FAIL wr_clr_same_cnt got=%h exp=%h", rd_fu_cnt, exp_cnt());
      end
      n_checks++;
      if (rd_fu_mask[3*NUM_WF+7] !== 1'b1 || rd_fu_mask !== exp_mask()) begin
         n_errors++; $display("FAIL wr_clr_same_mask got=%h exp=%h", rd_fu_mask, exp_mask());
      end
   endtask

   task automatic test_errors();
      logic [MW-1:0] before_mask = rd_fu_mask;
      drive(0, 1, 45, 1, 0, 0);
      tick();
      n_checks++;
      if (err_pulse !== 1'b1) begin
         n_errors++; $display("FAIL bad_write_err got=%b exp=1", err_pulse);
      end
      n_checks++;
      if (rd_fu_mask !== before_mask) begin
         n_errors++; $display("FAIL bad_write_state got=%h exp=%h", rd_fu_mask, before_mask);
      end
      drive(0, 0, 0, 0, 1, 3);
      tick();
      n_checks++;
      if (err_pulse !== 1'b0 || rd_fu_mask !== before_mask) begin
         n_errors++; $display("FAIL clr_invalid got=%b/%h exp=0/%h", err_pulse, rd_fu_mask, before_mask);
      end
      drive(0, 1, 63, 0, 1, 50);
      tick();
      n_checks++;
      if (err_pulse !== 1'b1) begin
         n_errors++; $display("FAIL bad_both_err got=%b exp=1", err_pulse);
      end
      idle(1);
      n_checks++;
      if (err_pulse !== 1'b0) begin
         n_errors++; $display("FAIL err_one_cycle got=%b exp=0", err_pulse);
      end
   endtask

   task automatic test_fill_reset();
      for (int w = 0; w < NUM_WF; w++) begin
         drive(0, 1, w, 3, 0, 0);
         tick();
      end
      n_checks++;
      if (rd_fu_cnt[3*CNT_W +: CNT_W] !== 6'd40 || rd_fu_cnt !== exp_cnt()) begin
         n_errors++; $display("FAIL fill_cnt got=%h exp=%h", rd_fu_cnt, exp_cnt());
      end
      drive(1, 1, 2, 1, 0, 0);
      tick();
      n_checks++;
      if (rd_fu_cnt !== '0 || rd_fu_mask !== '0) begin
         n_errors++; $display("FAIL reset_over_write got=%h/%h exp=0/0", rd_fu_cnt, rd_fu_mask);
      end
      idle(1);
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         int wid = ($urandom_range(0, 9) == 0) ? int'($urandom_range(40, 63)) : int'($urandom_range(0, 39));
         int cid = ($urandom_range(0, 9) == 0) ? int'($urandom_range(40, 63)) : int'($urandom_range(0, 39));
         if ($urandom_range(0, 4) == 0) cid = wid;
         drive(0, 1'($urandom_range(0, 1)), wid, int'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), cid);
         tick();
         exp_q.push_back(exp_mask());
         n_checks++;
         if (rd_fu_mask !== exp_q[0]) begin
            n_errors++; $display("FAIL rand_mask cyc=%0d got=%h exp=%h", i, rd_fu_mask, exp_q[0]);
         end
         void'(exp_q.pop_front());
         n_checks++;
         if (rd_fu_cnt !== exp_cnt()) begin
            n_errors++; $display("FAIL rand_cnt cyc=%0d got=%h exp=%h", i, rd_fu_cnt, exp_cnt());
         end
         n_checks++;
         if (err_pulse !== m_err) begin
            n_errors++; $display("FAIL rand_err cyc=%0d got=%b exp=%b", i, err_pulse, m_err);
         end
      end
      idle(1);
   endtask

   initial begin
      for (int w = 0; w < NUM_WF; w++) begin
         m_valid[w] = 0;
         m_tag[w]   = 0;
      end
      m_err = 0;
      drive(1, 0, 0, 0, 0, 0);
      test_reset();
      test_write();
      test_retag();
      test_same_cycle();
      test_errors();
      test_fill_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
